// File: rtl/firbank_arbiter.sv
// firbank_arbiter: round-robin arbiter that lets NUM_REQ filter engines share
// one coefficient ROM. A granted requester receives a burst of len+1
// consecutive ROM words, each returned two cycles after its address is issued.
module firbank_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned NUM_REQ_LOG2 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ*12-1:0]   addr_i,
  input  logic [NUM_REQ*8-1:0]    len_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [11:0]             bank_addr_o,
  input  logic [23:0]             bank_data_i,
  output logic [23:0]             data_o,
  output logic [NUM_REQ-1:0]      ack_o,
  output logic                    last_o,
  output logic                    busy_o
);

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } state_t;

  state_t                  state;
  logic [NUM_REQ_LOG2-1:0] last_gnt;
  logic [NUM_REQ_LOG2-1:0] owner;
  logic [7:0]              cnt;

  // Arbitration result for the current IDLE cycle.
  logic                    win_found;
  logic [NUM_REQ_LOG2-1:0] win_idx;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [11:0]             win_addr;
  logic [7:0]              win_len;

  // Read-path stage 1: tags the address issued in the previous cycle while
  // the ROM produces its data.
  logic                    p1_valid;
  logic [NUM_REQ_LOG2-1:0] p1_owner;
  logic                    p1_last;
  logic [NUM_REQ-1:0]      p1_onehot;

  // Round-robin search starting just after the previous winner, with wrap.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    win_len   = '0;
    idx       = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last_gnt) + k) % int'(NUM_REQ);
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = NUM_REQ_LOG2'(idx);
        win_addr  = addr_i[idx*12 +: 12];
        win_len   = len_i[idx*8 +: 8];
      end
    end
  end

  // One-hot decode of the arbitration winner.
  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // One-hot decode of the owner tag riding with the in-flight word.
  always_comb begin
    p1_onehot           = '0;
    p1_onehot[p1_owner] = 1'b1;
  end

  // Arbitration / address-generation FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      gnt_o       <= '0;
      busy_o      <= 1'b0;
      bank_addr_o <= '0;
      cnt         <= '0;
      owner       <= '0;
      last_gnt    <= NUM_REQ_LOG2'(NUM_REQ - 1);
    end else begin
      gnt_o <= '0;
      unique case (state)
        StIdle: begin
          if (win_found) begin
            gnt_o       <= win_onehot;
            state       <= StBurst;
            busy_o      <= 1'b1;
            bank_addr_o <= win_addr;
            cnt         <= win_len;
            owner       <= win_idx;
            last_gnt    <= win_idx;
          end
        end
        StBurst: begin
          // Requests are ignored here; the address holds once the burst ends.
          if (cnt != 8'd0) begin
            bank_addr_o <= bank_addr_o + 12'd1;
            cnt         <= cnt - 8'd1;
          end else begin
            state  <= StIdle;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read pipeline: tag the issued address, then capture ROM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_owner <= '0;
      p1_last  <= 1'b0;
      ack_o    <= '0;
      last_o   <= 1'b0;
      data_o   <= '0;
    end else begin
      p1_valid <= (state == StBurst);
      p1_owner <= owner;
      p1_last  <= (state == StBurst) && (cnt == 8'd0);
      ack_o    <= p1_valid ? p1_onehot : '0;
      last_o   <= p1_valid && p1_last;
      if (p1_valid) begin
        data_o <= bank_data_i;
      end
    end
  end

endmodule

// File: tb/tb_firbank_arbiter.sv
// Directed self-checking bench for firbank_arbiter with a one-cycle ROM model.
module tb_firbank_arbiter;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned NUM_REQ_LOG2 = 1;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*12-1:0] addr;
  logic [NUM_REQ*8-1:0]  len;
  logic [NUM_REQ-1:0]    gnt;
  logic [11:0]           bank_addr;
  logic [23:0]           bank_data;
  logic [23:0]           data;
  logic [NUM_REQ-1:0]    ack;
  logic                  last;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;

  firbank_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .NUM_REQ_LOG2 (NUM_REQ_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .addr_i      (addr),
    .len_i       (len),
    .gnt_o       (gnt),
    .bank_addr_o (bank_addr),
    .bank_data_i (bank_data),
    .data_o      (data),
    .ack_o       (ack),
    .last_o      (last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] rom(input logic [11:0] a);
    return {a ^ 12'h5A5, ~a};
  endfunction

  // ROM model: data for the address presented in cycle A appears in A+1.
  always @(posedge clk) bank_data <= rom(bank_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(bank_addr), 0);
    chk("rst_data", 32'(data), 0);
    rst = 1'b0;
  endtask

  // Single-requester burst; called at a negedge with the pipeline drained.
  task automatic do_burst(input int who, input logic [11:0] a, input logic [7:0] l);
    int n;
    logic [NUM_REQ-1:0] oh;
    logic [11:0] ea;
    n  = int'(l);
    oh = '0;
    oh[who] = 1'b1;
    addr[who*12 +: 12] = a;
    len[who*8 +: 8]    = l;
    req = oh;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      chk("b_gnt", 32'(gnt), (k == 1) ? 32'(oh) : 0);
      chk("b_busy", 32'(busy), (k <= n + 1) ? 1 : 0);
      if (k <= n + 1) begin
        ea = a + 12'(k - 1);
        chk("b_addr", 32'(bank_addr), 32'(ea));
      end
      if (k >= 3) begin
        ea = a + 12'(k - 3);
        chk("b_ack", 32'(ack), 32'(oh));
        chk("b_data", 32'(data), 32'(rom(ea)));
        chk("b_last", 32'(last), (k == n + 3) ? 1 : 0);
      end else begin
        chk("b_ack0", 32'(ack), 0);
      end
      if (k == 1) begin
        // Drop the request and disturb the inputs: the burst was captured.
        req = '0;
        addr[who*12 +: 12] = ~a;
        len[who*8 +: 8]    = ~l;
      end
    end
  endtask

  initial begin
    int ngr;
    logic [NUM_REQ-1:0] g1;
    logic [NUM_REQ-1:0] g2;
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    len  = '0;

    // Basic burst from requester 0.
    do_reset();
    do_burst(0, 12'h100, 8'd3);

    // Simultaneous requests: 0 first, one IDLE cycle, then 1.
    do_reset();
    addr = {12'h300, 12'h200};
    len  = {8'd1, 8'd1};
    req  = 2'b11;
    @(negedge clk);
    chk("s_gnt1", 32'(gnt), 32'h1);
    chk("s_addr1", 32'(bank_addr), 32'h200);
    chk("s_busy1", 32'(busy), 1);
    req = 2'b10;
    @(negedge clk);
    chk("s_gnt2", 32'(gnt), 0);
    chk("s_addr2", 32'(bank_addr), 32'h201);
    chk("s_ack2", 32'(ack), 0);
    @(negedge clk);
    chk("s_gnt3", 32'(gnt), 0);
    chk("s_busy3", 32'(busy), 0);
    chk("s_ack3", 32'(ack), 32'h1);
    chk("s_data3", 32'(data), 32'(rom(12'h200)));
    chk("s_last3", 32'(last), 0);
    @(negedge clk);
    chk("s_gnt4", 32'(gnt), 32'h2);
    chk("s_addr4", 32'(bank_addr), 32'h300);
    chk("s_ack4", 32'(ack), 32'h1);
    chk("s_data4", 32'(data), 32'(rom(12'h201)));
    chk("s_last4", 32'(last), 1);
    req = 2'b00;
    @(negedge clk);
    chk("s_addr5", 32'(bank_addr), 32'h301);
    chk("s_ack5", 32'(ack), 0);
    @(negedge clk);
    chk("s_ack6", 32'(ack), 32'h2);
    chk("s_data6", 32'(data), 32'(rom(12'h300)));
    chk("s_last6", 32'(last), 0);
    @(negedge clk);
    chk("s_ack7", 32'(ack), 32'h2);
    chk("s_data7", 32'(data), 32'(rom(12'h301)));
    chk("s_last7", 32'(last), 1);
    @(negedge clk);
    chk("s_ack8", 32'(ack), 0);

    // Address wrap at the top of the ROM.
    do_reset();
    do_burst(0, 12'hFFE, 8'd3);

    // Both requests held: grants alternate, acks follow their owners.
    do_reset();
    addr = {12'h700, 12'h600};
    len  = {8'd0, 8'd0};
    req  = 2'b11;
    ngr  = 0;
    g1   = '0;
    g2   = '0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      @(negedge clk);
      chk("rr_ack", 32'(ack), 32'(g2));
      if (gnt != '0) begin
        chk("rr_gnt", 32'(gnt), (ngr % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_addr", 32'(bank_addr), (ngr % 2 == 0) ? 32'h600 : 32'h700);
        ngr++;
        if (ngr == 6) req = '0;
      end
      g2 = g1;
      g1 = gnt;
    end
    chk("rr_count", 32'(ngr), 6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rr_drain", 32'(ack), 32'(g2));
      g2 = g1;
      g1 = gnt;
    end

    // Reset in the middle of an 8-word burst.
    do_reset();
    addr[11:0] = 12'h400;
    len[7:0]   = 8'd7;
    req = 2'b01;
    @(negedge clk);
    chk("m_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("m_addr3", 32'(bank_addr), 32'h402);
    rst = 1'b1;
    @(negedge clk);
    chk("m_busy", 32'(busy), 0);
    chk("m_ack", 32'(ack), 0);
    chk("m_addr", 32'(bank_addr), 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("m_ack_after", 32'(ack), 0);
      chk("m_busy_after", 32'(busy), 0);
    end
    do_burst(1, 12'h500, 8'd2);

    // Length extremes: single word and full 256-word burst.
    do_reset();
    do_burst(0, 12'h010, 8'd0);
    do_burst(0, 12'h800, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
